// File: rtl/bcd_counter_pkg.sv
// Shared types and segment encoding for the two-digit BCD counter.
package bcd_counter_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef logic [3:0] bcd_t;

    // Active-low {dp,g,f,e,d,c,b,a}; dp always off, non-decimal codes blank.
    function automatic logic [7:0] seg7(input bcd_t d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, sample-tick prescaler and a
// two-sample agreement filter. Emits the debounced level and a one-cycle
// pulse on each press (1->0) edge.
module btn_debounce #(
    parameter int P_SAMPLE_DIV = 2**14
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);
    localparam int CW = (P_SAMPLE_DIV > 1) ? $clog2(P_SAMPLE_DIV) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] pre;
    logic          tick;
    logic [1:0]    samp;
    logic [1:0]    vld_pipe;  // marks which sample slots hold real samples since reset
    logic          armed;     // a genuine release has been seen since reset

    assign tick = (pre == CW'(P_SAMPLE_DIV - 1));

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], btn_n};
    end

    // Free-running sample-period prescaler.
    always_ff @(posedge clk) begin
        if (rst)       pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + CW'(1);
    end

    // Shift the synced level into the sample pair once per tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp     <= 2'b11;
            vld_pipe <= 2'b00;
        end else if (tick) begin
            samp     <= {samp[0], sync[1]};
            vld_pipe <= {vld_pipe[0], 1'b1};
        end
    end

    // Follow agreeing samples; a press held across reset is ignored until
    // a real release has been observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b1;
            press <= 1'b0;
            armed <= 1'b0;
        end else begin
            press <= 1'b0;
            if (samp[1] == samp[0] && samp[0] != level) begin
                level <= samp[0];
                if (!samp[0] && armed) press <= 1'b1;
            end
            if (vld_pipe[1] && samp == 2'b11) armed <= 1'b1;
        end
    end

endmodule

// File: rtl/bcd_counter_top.sv
// Board top: debounced BTN[0] drives a 00..99 BCD counter shown on
// HEX1:HEX0 and as raw BCD on LED.
module bcd_counter_top
    import bcd_counter_pkg::*;
#(
    parameter int P_SAMPLE_DIV = 2**14
) (
    input  logic       CLK1,
    input  logic       RST,
    input  logic [1:0] BTN,
    input  logic [9:0] SW,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5,
    output logic [9:0] LED
);
    bcd_t ones, tens;
    logic inc;
    logic db_level;
    logic unused;

    assign unused = ^{SW, BTN[1], db_level};

    btn_debounce #(.P_SAMPLE_DIV(P_SAMPLE_DIV)) u_db (
        .clk   (CLK1),
        .rst   (RST),
        .btn_n (BTN[0]),
        .level (db_level),
        .press (inc)
    );

    // Two-digit decimal counter, 99 wraps to 00.
    always_ff @(posedge CLK1) begin
        if (RST) begin
            ones <= '0;
            tens <= '0;
        end else if (inc) begin
            if (ones == 4'd9) begin
                ones <= '0;
                tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

    // Display outputs are pure decode of the digit registers.
    always_comb begin
        HEX0 = seg7(ones);
        HEX1 = seg7(tens);
        HEX2 = SEG_BLANK;
        HEX3 = SEG_BLANK;
        HEX4 = SEG_BLANK;
        HEX5 = SEG_BLANK;
        LED  = {2'b00, tens, ones};
    end

endmodule

// File: tb/tb_bcd_counter_top.sv
// Randomized bench for bcd_counter_top against an integer press-count model.
module tb_bcd_counter_top;
    localparam int DIV  = 16;
    localparam int SAFE = 3 * DIV + 3;   // worst-case recognition bound

    logic       CLK1 = 1'b0;
    logic       RST  = 1'b1;
    logic [1:0] BTN  = 2'b11;
    logic [9:0] SW   = '0;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LED;

    int n_chk = 0;
    int n_fail = 0;
    int cnt = 0;   // model: presses since reset, modulo 100

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    bcd_counter_top #(.P_SAMPLE_DIV(DIV)) dut (
        .CLK1(CLK1), .RST(RST), .BTN(BTN), .SW(SW),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .LED(LED)
    );

    always #10 CLK1 = ~CLK1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK1);
        #1;
    endtask

    function automatic logic [9:0] exp_led(input int c);
        logic [3:0] t, o;
        t = 4'(c / 10);
        o = 4'(c % 10);
        return {2'b00, t, o};
    endfunction

    task automatic chk_disp(input string tag);
        @(negedge CLK1);
        chk({tag, "_led"},  32'(LED),  32'(exp_led(cnt)));
        chk({tag, "_hex0"}, 32'(HEX0), 32'(seg_tab[cnt % 10]));
        chk({tag, "_hex1"}, 32'(HEX1), 32'(seg_tab[cnt / 10]));
    endtask

    task automatic do_press(input int hold, input int rel);
        BTN[0] = 1'b0;
        cyc(hold);
        BTN[0] = 1'b1;
        cyc(rel);
        cnt = (cnt + 1) % 100;
    endtask

    task automatic rnd_press();
        do_press(SAFE + int'($urandom_range(0, 80)), SAFE + int'($urandom_range(0, 80)));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc(10);
        RST = 1'b0;
        cnt = 0;
    endtask

    initial begin
        SW = 10'($urandom);
        cyc(1);
        do_reset();
        @(negedge CLK1);
        chk("rst_hex0", 32'(HEX0), 32'hC0);
        chk("rst_hex1", 32'(HEX1), 32'hC0);
        chk("rst_hex2", 32'(HEX2), 32'hFF);
        chk("rst_hex3", 32'(HEX3), 32'hFF);
        chk("rst_hex4", 32'(HEX4), 32'hFF);
        chk("rst_hex5", 32'(HEX5), 32'hFF);
        chk("rst_led",  32'(LED),  32'h000);
        cyc(100);

        // First 19 presses, each checked digit by digit.
        for (int i = 1; i <= 19; i++) begin
            SW = 10'($urandom);
            BTN[1] = 1'($urandom);
            rnd_press();
            chk_disp("press");
        end
        chk("press10_19", 32'(LED), 32'h019);

        // Up to 99, with occasional short glitches that must be ignored.
        while (cnt != 99) begin
            if ($urandom_range(0, 3) == 0) begin
                BTN[0] = 1'b0;
                cyc(int'($urandom_range(1, DIV - 1)));
                BTN[0] = 1'b1;
                cyc(SAFE);
            end
            rnd_press();
        end
        chk_disp("at99");
        chk("at99_led", 32'(LED), 32'h099);
        rnd_press();
        chk_disp("wrap");
        chk("wrap_led", 32'(LED), 32'h000);

        // Glitch shorter than one sample period.
        BTN[0] = 1'b0;
        cyc(DIV - 1);
        BTN[0] = 1'b1;
        cyc(2 * SAFE);
        chk_disp("glitch");

        // Long hold gives one increment only.
        do_press(2000, 2 * SAFE);
        chk_disp("hold");

        // Reach 37, then reset while the button is held.
        while (cnt != 37) rnd_press();
        chk_disp("at37");
        BTN[0] = 1'b0;
        cyc(2 * SAFE);
        cnt = cnt + 1;
        chk_disp("held38");
        do_reset();
        @(negedge CLK1);
        chk("rst_held_led", 32'(LED), 32'h000);
        cyc(300);
        chk_disp("still_held");
        BTN[0] = 1'b1;
        cyc(2 * SAFE);
        chk_disp("released");
        rnd_press();
        chk_disp("fresh");
        chk("fresh_led", 32'(LED), 32'h001);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
